// File: rtl/eq_pkg.sv
// Shared constants, gain type and controller state encoding for the
// equalizer gain-control block.
package eq_pkg;

    localparam int NBANDS = 8;
    localparam int GW     = 16;
    localparam int BW     = $clog2(NBANDS);

    typedef logic [GW-1:0] gain_t;

    // Q2.14: 16'h4000 is a gain of 1.0.
    localparam gain_t UNITY = 16'h4000;
    localparam gain_t STEP  = 16'h0040;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RAMP
    } gctl_state_e;

endpackage

// File: rtl/gain_ramp_step.sv
// Combinational single-band ramp step: moves a live gain at most STEP
// toward its target and flags when the target is reached.
module gain_ramp_step
    import eq_pkg::*;
(
    input  gain_t g_i,
    input  gain_t target_i,
    output gain_t g_o,
    output logic  done_o
);

    logic signed [GW:0] diff;
    logic        [GW:0] mag;

    always_comb begin
        // Extra bit keeps the unsigned difference exact in both directions.
        diff = $signed({1'b0, target_i}) - $signed({1'b0, g_i});
        mag  = diff[GW] ? unsigned'(-diff) : unsigned'(diff);

        if (mag <= {1'b0, STEP}) begin
            g_o = target_i;
        end else if (!diff[GW]) begin
            g_o = g_i + STEP;
        end else begin
            g_o = g_i - STEP;
        end

        done_o = (g_o == target_i);
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// Equalizer gain controller: shadow -> target transfer on sample strobes.
// EQ_GAIN_RAMP_EN selects per-sample ramping; undefined, gains jump on load.
module eq_gain_ctrl
    import eq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_tick,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [BW-1:0] wr_band,
    input  gain_t         wr_gain,
    input  logic          commit,
    output gain_t         g [NBANDS-1:0],
    output logic          busy
);

    gctl_state_e state_q, state_d;
    gain_t       shadow_q [NBANDS-1:0];
    gain_t       shadow_d [NBANDS-1:0];
    gain_t       target_q [NBANDS-1:0];
    gain_t       target_d [NBANDS-1:0];
    gain_t       g_q      [NBANDS-1:0];
    gain_t       g_d      [NBANDS-1:0];
    logic        busy_q, busy_d;

    // Shadow is frozen while a transfer is armed.
    assign wr_ready = (state_q != ARMED);

`ifdef EQ_GAIN_RAMP_EN
    gain_t             g_step    [NBANDS-1:0];
    logic [NBANDS-1:0] band_done;

    for (genvar i = 0; i < NBANDS; i++) begin : g_band
        gain_ramp_step u_step (
            .g_i      (g_q[i]),
            .target_i (target_q[i]),
            .g_o      (g_step[i]),
            .done_o   (band_done[i])
        );
    end
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves a variable unassigned (no latches).
        state_d  = state_q;
        shadow_d = shadow_q;
        target_d = target_q;
        g_d      = g_q;

        if (wr_valid && wr_ready && (int'(wr_band) < NBANDS)) begin
            shadow_d[wr_band] = wr_gain;
        end

        case (state_q)
            IDLE: begin
                if (commit) state_d = ARMED;
            end
            ARMED: begin
                if (sample_tick) begin
                    target_d = shadow_q;
`ifdef EQ_GAIN_RAMP_EN
                    state_d  = RAMP;
`else
                    g_d      = shadow_q;
                    state_d  = IDLE;
`endif
                end
            end
            RAMP: begin
`ifdef EQ_GAIN_RAMP_EN
                if (sample_tick) begin
                    g_d = g_step;
                    if (commit)          state_d = ARMED;
                    else if (&band_done) state_d = IDLE;
                end else if (commit) begin
                    state_d = ARMED;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

`ifdef EQ_GAIN_RAMP_EN
        busy_d = (state_d != IDLE);
`else
        busy_d = (state_d == ARMED);
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: the gain arrays are architectural state the equalizer sees,
        // so they are reset to unity rather than left as uninitialised RAM.
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            for (int i = 0; i < NBANDS; i++) begin
                shadow_q[i] <= UNITY;
                target_q[i] <= UNITY;
                g_q[i]      <= UNITY;
            end
        end else begin
            // NOTE: non-blocking updates so all registers take their next
            // value from the same pre-edge snapshot.
            state_q  <= state_d;
            busy_q   <= busy_d;
            shadow_q <= shadow_d;
            target_q <= target_d;
            g_q      <= g_d;
        end
    end

    assign g    = g_q;
    assign busy = busy_q;

endmodule

// File: doc/eq_gain_ctrl.md
Name: eq_gain_ctrl

Overview:
- Upstream control stage for the 8-band equalizer. Drives its `g[7:0]` gain vector.
- Host writes per-band gains into shadow registers over a valid/ready port. A commit pulse arms an atomic transfer to the targets.
- Transfer happens on the next sample strobe, then the live gains ramp toward target one step per sample, avoiding zipper noise.
- Live gains change only on `sample_tick`, so the equalizer never sees a gain change mid-sample.

Parameters:
- NBANDS, 8, number of bands (band index width = $clog2(NBANDS)).
- GW, 16, gain width; unsigned Q2.14.
- UNITY, 16'h4000, reset/default gain (1.0).
- STEP, 16'h0040, maximum per-sample change of a live gain.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- sample_tick  in  1  one-cycle strobe, once per audio sample.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_band  in  $clog2(NBANDS)  target band index.
- wr_gain  in  GW  new shadow gain.
- commit  in  1  one-cycle pulse: arm shadow-to-target transfer.
- g  out  GW x NBANDS (unpacked [NBANDS-1:0])  live gains to the equalizer.
- busy  out  1  high in ARMED or RAMP.

Behaviour:
- Reset (sync, rst=1): shadow, target and g all = UNITY; state IDLE; wr_ready=1; busy=0. Reset overrides every input, including mid-ramp and ARMED.
- Write: on wr_valid && wr_ready, shadow[wr_band] <= wr_gain next edge. wr_band >= NBANDS is accepted and discarded.
- wr_ready = 0 only in ARMED; shadow is frozen until copied.
- States:
  - IDLE: g == target. commit -> ARMED.
  - ARMED: on sample_tick, target <= shadow (all bands at once), then -> RAMP. commit while ARMED is ignored.
  - RAMP: on each sample_tick, every band steps toward target (rule below). Transitions on that same tick:
    - commit on the tick cycle -> ARMED; the step is still applied.
    - otherwise, if all bands equal target after the update -> IDLE.
  - RAMP, non-tick cycle: commit -> ARMED.
- Step rule per band:
  - d = target - g, computed in GW+1 signed width.
  - If |d| <= STEP, g <= target.
  - Else g <= g + STEP when d > 0, or g - STEP when d < 0.
  - No overflow is possible, since g moves monotonically toward target.
- Ramp tick count: RAMP lasts ceil(max_band |target-g| / STEP) ticks. A commit whose shadow equals the current g still passes through RAMP for exactly 1 tick.
- Latencies:
  - commit to target load: first sample_tick strictly after the commit cycle. A tick coincident with commit in IDLE does not load.
  - target load to first g change: the next sample_tick after the load.
- Write and commit in the same cycle: the write lands in shadow and is included in the transfer.
- Write in RAMP: allowed; affects only the next commit.
- g and busy are registered outputs.

Optional Feature:
- Macro: EQ_GAIN_RAMP_EN.
- Defined: ramping exactly as above.
- Not defined:
  - The ARMED tick loads target and g in the same cycle (g <= shadow), then -> IDLE. RAMP is unreachable.
  - busy is high only in ARMED.
  - STEP is unused.

Decomposition:
- Package eq_pkg:
  - GW, NBANDS, UNITY constants.
  - typedef gain_t (logic [GW-1:0]).
  - state enum gctl_state_e {IDLE, ARMED, RAMP}.
- Sub-module gain_ramp_step: combinational per-band step (g, target, STEP -> next g, done); instantiated NBANDS times via generate.

Test Plan:
- Reset, then no stimulus for 10 ticks -> all g = 16'h4000, busy = 0, wr_ready = 1.
- Write band 3 = 16'h4100, commit, tick, 4 further ticks -> g[3] = 4040, 4080, 40C0, 4100; back to IDLE after the 4th step. Other bands stay at 4000.
- Write band 0 = 16'h4010, commit -> g[0] = 4010 on the first step tick (|d| <= STEP).
- In ARMED, wr_valid=1 -> wr_ready = 0 and shadow unchanged. commit and sample_tick in the same cycle from IDLE -> target loads on the following tick, not this one.
- Mid-ramp: write band 3 = 16'h4000 and commit -> step continues. On the next tick target[3] = 4000; g reverses by 16'h0040 per tick until it equals 4000.
- Mid-ramp rst = 1 for 1 cycle -> g, target and shadow = 4000, state IDLE on the next edge. Repeat the ramp tests with EQ_GAIN_RAMP_EN undefined -> g jumps to 4100 on the load tick.
